// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants, FSM state type and parity helper for uart_tx / uart_rx
// Contents: default CLKS_PER_BIT, data/frame bit counts, uart_state_e.
// Build option: UART_TX_PARITY_EN adds the PARITY state, the 11-bit frame and parity_bit().
package uart_pkg;
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } uart_state_e;
`ifdef UART_TX_PARITY_EN
  function automatic logic parity_bit(input logic [7:0] b, input logic odd);
    return odd ? ~^b : ^b;
  endfunction
`endif
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO with registered full flag and occupancy count
// Ports: i_clk, i_rst (async, active-high), i_push/i_data (ignored while full),
//        i_pop (ignored while empty), o_data (head, combinational),
//        o_full (registered), o_empty, o_count (0..DEPTH).
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic full_q, push_ok, pop_ok;
  assign push_ok = i_push && !full_q;
  assign pop_ok = i_pop && cnt_q != '0;
  assign cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push_ok);
      rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
      cnt_q <= cnt_d;
      full_q <= cnt_d == CW'(DEPTH);
    end
  always_ff @(posedge i_clk)
    if (push_ok) mem_q[wr_ptr_q] <= i_data;
  assign o_data = mem_q[rd_ptr_q];
  assign o_full = full_q;
  assign o_empty = cnt_q == '0;
  assign o_count = cnt_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter, LSB first, fed through a byte FIFO
// Ports: i_clk, i_rst (async, active-high), i_tx_byte_rdy/i_tx_byte (push when o_tx_ready),
//        o_tx_ready (FIFO not full, registered), o_tx_serial (idles high),
//        o_tx_active (start..stop), o_tx_done (last clock of stop bit),
//        o_fifo_count (queued bytes, excluding the one on the wire).
// Build option: UART_TX_PARITY_EN inserts a parity bit (PARITY_ODD selects odd) for an 11-bit frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 16
`ifdef UART_TX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_tx_byte_rdy,
  input  logic [7:0]                   i_tx_byte,
  output logic                         o_tx_ready,
  output logic                         o_tx_serial,
  output logic                         o_tx_active,
  output logic                         o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  o_fifo_count
);
  localparam int BW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  uart_state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, fifo_data;
  logic fifo_full, fifo_empty, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d;
`endif
  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (i_tx_byte_rdy),
    .i_data  (i_tx_byte),
    .i_pop   (state_q == S_LOAD),
    .o_data  (fifo_data),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_count (o_fifo_count)
  );
  assign bit_end = baud_q == BW'(CLKS_PER_BIT - 1);
  // Baud counter only runs inside a bit cell and restarts at every cell boundary, so frames never drift.
  assign baud_d = (state_q == S_IDLE || state_q == S_LOAD || bit_end) ? '0 : baud_q + 1'b1;
  always_comb begin
    state_d = state_q;
    bit_d = bit_q;
    shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
`endif
    o_tx_serial = 1'b1;
    case (state_q)
      S_IDLE: state_d = fifo_empty ? S_IDLE : S_LOAD;
      S_LOAD: begin
        state_d = S_START;
        shift_d = fifo_data;
        bit_d = '0;
`ifdef UART_TX_PARITY_EN
        par_d = parity_bit(fifo_data, PARITY_ODD[0]);
`endif
      end
      S_START: begin
        o_tx_serial = 1'b0;
        state_d = bit_end ? S_DATA : S_START;
      end
      S_DATA: begin
        o_tx_serial = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d = bit_q + 1'b1;
`ifdef UART_TX_PARITY_EN
          state_d = bit_q == 3'(DATA_BITS - 1) ? S_PARITY : S_DATA;
`else
          state_d = bit_q == 3'(DATA_BITS - 1) ? S_STOP : S_DATA;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        o_tx_serial = par_q;
        state_d = bit_end ? S_STOP : S_PARITY;
      end
`endif
      S_STOP: state_d = !bit_end ? S_STOP : fifo_empty ? S_IDLE : S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= S_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
`ifdef UART_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  assign o_tx_ready = !fifo_full;
  assign o_tx_active = state_q != S_IDLE && state_q != S_LOAD;
  assign o_tx_done = state_q == S_STOP && bit_end;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo against a frame-timing reference model
module tb_uart_tx_fifo;
  localparam int CPB = 16;
  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PODD = 0;
  localparam int NB = uart_pkg::FRAME_BITS;
  localparam int FL = NB * CPB;
  logic clk = 1'b0, rst = 1'b1, byte_rdy = 1'b0;
  logic [7:0] tx_byte = '0;
  logic tx_ready, tx_serial, tx_active, tx_done;
  logic [CW-1:0] fifo_count;
  typedef struct {
    longint p;
    logic [7:0] b;
  } frame_t;
  frame_t fq[$];
  longint n = 0, last_end = -1000;
  int vec = 0, errs = 0;
  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
`ifdef UART_TX_PARITY_EN
    ,
    .PARITY_ODD(PODD)
`endif
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_tx_byte_rdy (byte_rdy),
    .i_tx_byte     (tx_byte),
    .o_tx_ready    (tx_ready),
    .o_tx_serial   (tx_serial),
    .o_tx_active   (tx_active),
    .o_tx_done     (tx_done),
    .o_fifo_count  (fifo_count)
  );
  always #10 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, n);
    end
  endtask
  // Model: a byte accepted at edge a leaves the FIFO at edge max(a+2, previous frame end + 1);
  // its frame then occupies the line for FL clocks starting right after that edge.
  function automatic int queued(input longint t);
    int c = 0;
    foreach (fq[i]) if (fq[i].p > t) c++;
    return c;
  endfunction
  function automatic logic line_at(input longint t);
    foreach (fq[i])
      if (fq[i].p <= t && t < fq[i].p + FL) begin
        int k = int'((t - fq[i].p) / CPB);
        logic [7:0] b = fq[i].b;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return PODD != 0 ? ~^b : ^b;
        return 1'b1;
      end
    return 1'b1;
  endfunction
  function automatic logic active_at(input longint t);
    foreach (fq[i]) if (fq[i].p <= t && t < fq[i].p + FL) return 1'b1;
    return 1'b0;
  endfunction
  function automatic logic done_at(input longint t);
    foreach (fq[i]) if (fq[i].p + FL - 1 == t) return 1'b1;
    return 1'b0;
  endfunction
  task automatic step(input logic push, input logic [7:0] b);
    logic acc;
    longint p;
    byte_rdy = push;
    tx_byte = b;
    acc = push && !rst && queued(n) < DEPTH;
    @(posedge clk);
    n++;
    if (rst) begin
      fq.delete();
      last_end = -1000;
    end else if (acc) begin
      p = (n + 2 > last_end + 1) ? n + 2 : last_end + 1;
      fq.push_back('{p, b});
      last_end = p + FL;
    end
    while (fq.size() > 0 && fq[0].p + FL <= n) void'(fq.pop_front());
    #1;
    byte_rdy = 1'b0;
    check("serial", tx_serial, line_at(n));
    check("ready", tx_ready, queued(n) < DEPTH);
    check("count", fifo_count, queued(n));
    check("active", tx_active, active_at(n));
    check("done", tx_done, done_at(n));
  endtask
  task automatic wait_evt(input string tag, input bit want_done, input longint n0, input int exp_d);
    int k = 0;
    while (k < 4000 && !(want_done ? tx_done : !tx_serial)) begin
      step(1'b0, 8'h00);
      k++;
    end
    check(tag, 32'(n - n0), exp_d);
  endtask
  task automatic drain();
    int k = 0;
    while (fq.size() > 0 && k < 20000) begin
      step(1'b0, 8'h00);
      k++;
    end
    repeat (3) step(1'b0, 8'h00);
  endtask
  initial begin
    longint n0;
    int pct;
    repeat (3) step(1'b0, 8'h00);
    rst = 1'b0;
    step(1'b0, 8'h00);
    step(1'b1, 8'hAB);
    n0 = n;
    wait_evt("start_lat", 1'b0, n0, 2);
    wait_evt("done_lat", 1'b1, n0, FL + 1);
    drain();
    step(1'b1, 8'h3F);
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    wait_evt("done_f1", 1'b1, n - 2, FL + 1);
    step(1'b0, 8'h00);
    check("gap_high", tx_serial, 1'b1);
    step(1'b0, 8'h00);
    check("gap_low", tx_serial, 1'b0);
    drain();
    for (int i = 0; i < 18; i++) step(1'b1, 8'($urandom));
    check("full_count", fifo_count, DEPTH);
    check("full_ready", tx_ready, 1'b0);
    drain();
    step(1'b1, 8'h55);
    repeat (2 + 4 * CPB + CPB / 2) step(1'b0, 8'h00);
    #4 rst = 1'b1;
    #1;
    fq.delete();
    last_end = -1000;
    check("rst_serial", tx_serial, 1'b1);
    check("rst_count", fifo_count, 0);
    check("rst_active", tx_active, 1'b0);
    step(1'b0, 8'h00);
    rst = 1'b0;
    step(1'b1, 8'hA5);
    n0 = n;
    wait_evt("post_rst_done", 1'b1, n0, FL + 1);
    drain();
    step(1'b1, 8'hC3);
    step(1'b0, 8'h00);
    step(1'b1, 8'h5A);
    check("pushpop_count", fifo_count, 1);
    drain();
    for (int i = 0; i < 3000; i++) begin
      pct = (i / 500) % 3 == 0 ? 2 : (i / 500) % 3 == 1 ? 30 : 90;
      step(($urandom % 100) < pct, 8'($urandom));
    end
    drain();
    check("final_idle", tx_active, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
